if_stage: RTL and testbench

//  Instruction-fetch stage, directly upstream of the decode stage. Owns the PC and issues one

---
 rtl/if_stage.sv | 198 +++++++++++++++++++
 tb/tb_if_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage sitting directly in front of decode. It owns the PC,
//   keeps at most one read outstanding on the sram-like instruction port, and
//   holds each fetched word in a registered output slot until decode takes it.
//   Branch/jump redirects from decode take effect after the delay slot.
//   Exception/ERET flushes restart fetch at flush_pc.
//
// Parameters
//   RESET_PC      first fetch address after reset
//
// Ports
//   clk           clock (single domain)
//   resetn        asynchronous active-low reset
//   inst_req      fetch request (address handshake with inst_addr_ok)
//   inst_addr     fetch address, always equal to the current pc
//   inst_addr_ok  request accepted this cycle
//   inst_data_ok  read data valid this cycle
//   inst_rdata    read data
//   id_allowin    decode can accept an instruction this cycle
//   br_valid      one-cycle pulse: taken branch/jump entered decode
//   br_target     redirect target, qualified by br_valid
//   flush         exception/ERET flush, highest priority
//   flush_pc      restart address, qualified by flush
//   if_valid      output slot holds a valid entry
//   if_pc         PC of the held entry
//   if_inst       held instruction word (0 for a fetch fault)
//   if_adel       held entry is an address-error fetch fault
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    localparam logic [1:0] S_REQ    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;
    localparam logic [1:0] S_CANCEL = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;
    logic        r_ds_issued;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_if_adel;

    logic        w_pc_aligned;
    logic        w_addr_hs;
    logic        w_xfer;
    logic [31:0] w_pc_inc;
    logic [31:0] w_npc;
    logic [1:0]  w_state_nxt;

    assign w_pc_aligned = (r_pc[1:0] == 2'b00);

    // Request is gated by resetn so nothing is issued while reset is held.
    assign inst_req  = resetn & (r_state == S_REQ) & w_pc_aligned & ~flush;
    assign inst_addr = r_pc;

    assign w_addr_hs = inst_req & inst_addr_ok;
    assign w_xfer    = (r_state == S_FULL) & id_allowin;
    assign w_pc_inc  = r_pc + 32'd4;

    // A branch arriving in the same cycle as the delay-slot request steers
    // the following fetch straight to its target; otherwise a pending
    // redirect captured earlier is used.
    assign w_npc = br_valid  ? br_target :
                   r_br_pend ? r_br_tgt  :
                               w_pc_inc;

    assign if_valid = (r_state == S_FULL);
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;
    assign if_adel  = r_if_adel;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            // Anything that may still owe us a data beat must absorb it first.
            // An aligned REQ seeing addr_ok is treated as possibly committed
            // by the slave even though inst_req is masked this cycle.
            if ((r_state == S_WAIT) || (r_state == S_CANCEL) ||
                ((r_state == S_REQ) && w_pc_aligned && inst_addr_ok)) begin
                w_state_nxt = S_CANCEL;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!w_pc_aligned) begin
                        w_state_nxt = S_FULL;
                    end else if (w_addr_hs) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        w_state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_xfer) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_CANCEL: begin
                    if (inst_data_ok) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // Control state, pc and the output slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_br_pend   <= 1'b0;
            r_ds_issued <= 1'b0;
            r_if_pc     <= RESET_PC;
            r_if_inst   <= 32'd0;
            r_if_adel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (flush) begin
                r_pc <= flush_pc;
            end else if (w_addr_hs) begin
                r_pc <= w_npc;
            end else if (br_valid && r_ds_issued) begin
                // Delay slot already requested: pc has moved past it, so
                // overwrite it with the target.
                r_pc <= br_target;
            end

            if (flush || w_addr_hs) begin
                r_br_pend <= 1'b0;
            end else if (br_valid && !r_ds_issued) begin
                r_br_pend <= 1'b1;
            end

            // The first request accepted after a transfer is the delay slot.
            if (flush) begin
                r_ds_issued <= 1'b0;
            end else if (w_addr_hs) begin
                r_ds_issued <= 1'b1;
            end else if (w_xfer) begin
                r_ds_issued <= 1'b0;
            end

            if (!flush) begin
                if ((r_state == S_REQ) && !w_pc_aligned) begin
                    r_if_pc   <= r_pc;
                    r_if_inst <= 32'd0;
                    r_if_adel <= 1'b1;
                end else if ((r_state == S_WAIT) && inst_data_ok) begin
                    r_if_pc   <= r_fetch_pc;
                    r_if_inst <= inst_rdata;
                    r_if_adel <= 1'b0;
                end
            end
        end
    end

    // Data-only registers: meaningful only when qualified by control state.
    always_ff @(posedge clk) begin
        if (w_addr_hs) begin
            r_fetch_pc <= r_pc;
        end
        if (!flush && br_valid && !r_ds_issued && !w_addr_hs) begin
            r_br_tgt <= br_target;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } ent_t;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic        br_valid;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    // memory model state
    logic        mem_ok_en;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;

    ent_t        q_exp[$];
    logic [31:0] q_addr[$];
    int          checks;
    int          errors;
    int          xfer_cnt;
    int          vld_cycles;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0f0f_0000;
    endfunction

    assign inst_addr_ok = mem_ok_en & ~mem_busy;
    assign inst_data_ok = mem_busy & (mem_cnt == 0);
    assign inst_rdata   = inst_data_ok ? mem_word(mem_addr) : 32'hdead_beef;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .id_allowin  (id_allowin),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_adel     (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, scoreboard, then advance the memory model.
    task automatic cyc();
        logic        hs;
        logic        dok;
        logic [31:0] a;
        ent_t        e;
        @(negedge clk);
        hs  = inst_req & inst_addr_ok;
        dok = inst_data_ok;
        a   = inst_addr;
        if (if_valid) vld_cycles++;
        if (flush) q_exp.delete();
        if (hs) begin
            q_addr.push_back(a);
            e.pc   = a;
            e.inst = mem_word(a);
            e.adel = 1'b0;
            q_exp.push_back(e);
        end
        if (if_valid && id_allowin && !flush) begin
            xfer_cnt++;
            chk_val("sb_nonempty", {31'd0, (q_exp.size() > 0)}, 32'd1);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk_val("xfer_pc", if_pc, e.pc);
                chk_val("xfer_inst", if_inst, e.inst);
                chk_val("xfer_adel", {31'd0, if_adel}, {31'd0, e.adel});
            end
        end
        @(posedge clk);
        #1;
        if (dok) mem_busy = 1'b0;
        if (hs) begin
            mem_busy = 1'b1;
            mem_addr = a;
            mem_cnt  = mem_lat;
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end
        br_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] a);
        flush     = 1'b1;
        flush_pc  = a;
        mem_ok_en = 1'b0;
        cyc();
        mem_ok_en  = 1'b1;
        q_addr.delete();
        xfer_cnt   = 0;
        vld_cycles = 0;
    endtask

    task automatic chk_addrs(input string tag, input logic [31:0] a0,
                             input logic [31:0] a1, input logic [31:0] a2);
        chk_val({tag, "_n"}, q_addr.size(), 32'd3);
        if (q_addr.size() >= 3) begin
            chk_val({tag, "_a0"}, q_addr[0], a0);
            chk_val({tag, "_a1"}, q_addr[1], a1);
            chk_val({tag, "_a2"}, q_addr[2], a2);
        end
    endtask

    initial begin
        checks = 0; errors = 0; xfer_cnt = 0; vld_cycles = 0;
        mem_ok_en = 1'b1; mem_busy = 1'b0; mem_addr = 32'd0; mem_cnt = 0; mem_lat = 0;
        resetn = 1'b0; id_allowin = 1'b1; br_valid = 1'b0; br_target = 32'd0;
        flush = 1'b0; flush_pc = 32'd0;

        // reset state
        cyc();
        cyc();
        chk_val("rst_req", {31'd0, inst_req}, 32'd0);
        chk_val("rst_addr", inst_addr, RST_PC);
        chk_val("rst_valid", {31'd0, if_valid}, 32'd0);
        chk_val("rst_pc", if_pc, RST_PC);
        chk_val("rst_inst", if_inst, 32'd0);
        chk_val("rst_adel", {31'd0, if_adel}, 32'd0);
        chk_val("rst_nohs", q_addr.size(), 32'd0);

        // 1: sequential fetch, zero-wait memory
        resetn = 1'b1;
        repeat (9) cyc();
        chk_addrs("seq", 32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008);
        chk_val("seq_xfers", xfer_cnt, 32'd3);
        chk_val("seq_vld", vld_cycles, 32'd3);

        // 2: branch before delay slot requested
        redirect(32'h0000_0100);
        repeat (3) cyc();
        mem_ok_en = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h0000_0200;
        cyc();
        mem_ok_en = 1'b1;
        repeat (6) cyc();
        chk_addrs("br_pend", 32'h100, 32'h104, 32'h200);

        // 2b: branch in same cycle as delay-slot request
        redirect(32'h0000_0300);
        repeat (3) cyc();
        br_valid  = 1'b1;
        br_target = 32'h0000_0400;
        repeat (6) cyc();
        chk_addrs("br_same", 32'h300, 32'h304, 32'h400);

        // 3: branch after delay slot already requested
        redirect(32'h0000_0100);
        repeat (4) cyc();
        br_valid  = 1'b1;
        br_target = 32'h0000_0200;
        cyc();
        repeat (4) cyc();
        chk_addrs("br_ds", 32'h100, 32'h104, 32'h200);

        // 4: flush while waiting for data
        mem_lat = 2;
        redirect(32'h0000_0500);
        cyc();
        flush     = 1'b1;
        flush_pc  = 32'hbfc0_0380;
        mem_ok_en = 1'b0;
        vld_cycles = 0;
        cyc();
        mem_ok_en = 1'b1;
        chk_val("cancel_req", {31'd0, inst_req}, 32'd0);
        repeat (2) cyc();
        chk_val("cancel_vld", vld_cycles, 32'd0);
        chk_val("cancel_nreq", q_addr.size(), 32'd1);
        repeat (5) cyc();
        chk_val("cancel_n", q_addr.size(), 32'd2);
        if (q_addr.size() >= 2) chk_val("cancel_next", q_addr[1], 32'hbfc0_0380);
        chk_val("cancel_xfers", xfer_cnt, 32'd1);
        mem_lat = 0;

        // 5: decode stall while holding an instruction
        id_allowin = 1'b0;
        redirect(32'h0000_0600);
        repeat (2) cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_val("stall_vld", {31'd0, if_valid}, 32'd1);
            chk_val("stall_pc", if_pc, 32'h0000_0600);
            chk_val("stall_inst", if_inst, mem_word(32'h0000_0600));
            chk_val("stall_req", {31'd0, inst_req}, 32'd0);
        end
        chk_val("stall_naddr", q_addr.size(), 32'd1);
        id_allowin = 1'b1;
        cyc();
        chk_val("stall_xfer", xfer_cnt, 32'd1);

        // 6: misaligned restart address -> AdEL entry
        id_allowin = 1'b0;
        redirect(32'h0000_1002);
        chk_val("adel_req0", {31'd0, inst_req}, 32'd0);
        begin
            ent_t e;
            e.pc = 32'h0000_1002; e.inst = 32'd0; e.adel = 1'b1;
            q_exp.push_back(e);
        end
        cyc();
        chk_val("adel_vld", {31'd0, if_valid}, 32'd1);
        chk_val("adel_flag", {31'd0, if_adel}, 32'd1);
        chk_val("adel_pc", if_pc, 32'h0000_1002);
        chk_val("adel_inst", if_inst, 32'd0);
        chk_val("adel_req", {31'd0, inst_req}, 32'd0);
        id_allowin = 1'b1;
        cyc();
        chk_val("adel_xfer", xfer_cnt, 32'd1);
        chk_val("adel_nreq", q_addr.size(), 32'd0);
        chk_val("sb_left", q_exp.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
